cache_traffic_gen: RTL and testbench
====================================

# cache_traffic_gen

Parametrised memory-traffic generator driving the CPU side of the direct-mapped cache. Issues a programmable number of strided read, write, or write-then-read-verify accesses starting at a configurable address, advances only on completed handshakes, and counts read-data mismatches and total elapsed cycles for hit-rate and latency measurement. Sits in the cache testbench/top level in place of a processor model.

## Interface
- ADDR_W, 15, address width
- DATA_W, 32, data width
- START_ADDR, 1024, first address of each pass
- NUM_ACCESS, 8192, completed accesses per pass (>= 1)
- STRIDE, 1, address increment per completed access
- CNT_W, $clog2(NUM_ACCESS+1), access counter width (derived, not overridden)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- mode  input  2  0 = read pass, 1 = write pass, 2 = write pass then read pass, 3 = reserved (treated as 0)
- cache_ready  input  1  cache completes current request this cycle
- read_data  input  DATA_W  read data, valid when cache_ready and cache_read
- cache_read  output  1  read request
- cache_write  output  1  write request
- address  output  ADDR_W  request address
- write_data  output  DATA_W  write data
- busy  output  1  run in progress
- done  output  1  run complete, held until next start or reset
- error_count  output  16  read mismatches, saturating
- cycle_count  output  32  cycles spent busy, saturating

## Operation
- FSM: IDLE, WRITE, READ, DONE. Reset -> IDLE.
- IDLE/DONE + start: mode 1 or 2 -> WRITE; mode 0/3 -> READ. Load address = START_ADDR, access counter = 0, clear error_count and cycle_count, deassert done.
- WRITE/READ: hold cache_write/cache_read high continuously. Completion = cache_ready high at a rising edge with the request asserted. On completion: address <= address + STRIDE (modulo 2^ADDR_W, wraps silently), counter + 1.
- Completion of access NUM_ACCESS: WRITE with mode 2 -> READ (address reloads START_ADDR, counter 0); otherwise -> DONE.
- write_data = pattern(address) = address zero-extended, XOR 32'hA5A5_A5A5 truncated/extended to DATA_W; registered together with address.
- READ completion: compare read_data with pattern(address); mismatch increments error_count (saturates at 16'hFFFF). Compare applied in every mode.
- cache_ready while no request asserted (IDLE/DONE): ignored.
- start while busy: ignored; mode sampled only at accepted start.
- rst_n low mid-run: immediate return to IDLE, all outputs to reset values; the cache's in-flight access is abandoned.

## Timing
- Reset values: cache_read 0, cache_write 0, address START_ADDR, write_data pattern(START_ADDR), busy 0, done 0, error_count 0, cycle_count 0.
- All outputs registered. start at edge N -> request and busy high from cycle N+1.
- Zero-wait cache (cache_ready always 1): one access per cycle, address advances every cycle; a NUM_ACCESS pass takes exactly NUM_ACCESS cycles.
- Mode 2 transition: request type switches (cache_write 0, cache_read 1, address START_ADDR) in the cycle after the last write completion; no idle bubble.
- Final completion at edge M: requests low, busy low, done high from cycle M+1.
- cycle_count increments every cycle busy is high.

## Configuration
- CACHE_TRAFFIC_GEN_CHECK_EN defined: read-data comparison and error_count as above.
- Undefined: comparator and counter removed, read_data ignored, error_count tied to 0; all other behaviour identical.

## Structure
- Package cache_tb_pkg: mode enum (MODE_READ, MODE_WRITE, MODE_WRITE_READ), FSM state typedef, pattern XOR constant, pattern function.
- One sub-module natural: cache_traffic_checker (pattern compare + saturating error counter), instantiated only under CACHE_TRAFFIC_GEN_CHECK_EN.

## Test plan
- Defaults, mode 0, cache_ready tied 1, start pulse -> 8192 reads at 1024..9215, done after 8192 busy cycles, cycle_count 8192.
- mode 1, cache_ready high every 3rd cycle, NUM_ACCESS 4 -> writes to 1024..1027, each held 3 cycles, write_data 1024^A5A5A5A5 first, cycle_count 12.
- mode 2 against behavioural memory, NUM_ACCESS 16 -> 16 writes then 16 reads, no bubble, error_count 0; corrupt one word -> error_count 1.
- ADDR_W 4, START_ADDR 14, STRIDE 1, NUM_ACCESS 4 -> addresses 14, 15, 0, 1.
- rst_n asserted mid-READ with address 1030 -> outputs return to reset values asynchronously; start after release restarts at 1024.
- start pulsed while busy and cache_ready high in DONE -> no effect; start in DONE -> new run, counters cleared.

Source files
------------

// File: rtl/cache_tb_pkg.sv
// Shared types and the address-derived data pattern for the cache traffic generator.
package cache_tb_pkg;

    typedef enum logic [1:0] {
        MODE_READ       = 2'd0,
        MODE_WRITE      = 2'd1,
        MODE_WRITE_READ = 2'd2,
        MODE_RSVD       = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] PATTERN_XOR = 32'hA5A5_A5A5;

    // Computed wide; callers truncate to their own data width.
    function automatic logic [63:0] pattern(input logic [63:0] addr);
        return addr ^ 64'(PATTERN_XOR);
    endfunction

endpackage

// File: rtl/cache_traffic_checker.sv
// Compares completed read data against the expected pattern and counts mismatches (saturating).
module cache_traffic_checker #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              compare,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] expected,
    output logic [15:0]       error_count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_count <= 16'h0;
        end else if (clear) begin
            error_count <= 16'h0;
        end else if (compare && (read_data != expected) && (error_count != 16'hFFFF)) begin
            error_count <= error_count + 16'd1;
        end
    end

endmodule

// File: rtl/cache_traffic_gen.sv
// Strided read/write/write-then-verify traffic generator for the cache CPU port.
// Read-data checking is built only when CACHE_TRAFFIC_GEN_CHECK_EN is defined.
module cache_traffic_gen
    import cache_tb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned START_ADDR = 1024,
    parameter int unsigned NUM_ACCESS = 8192,
    parameter int unsigned STRIDE     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              cache_ready,
    input  logic [DATA_W-1:0] read_data,
    output logic              cache_read,
    output logic              cache_write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       error_count,
    output logic [31:0]       cycle_count
);

    localparam int unsigned       CNT_W = $clog2(NUM_ACCESS + 1);
    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(STRIDE);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_ACCESS - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              wr_rd, wr_rd_n;
    logic [ADDR_W-1:0] addr_n;
    logic              rd_n, wr_n, busy_n, done_n;
    logic              clear_c;

    // Next-state and next-output decode; request lines follow the state they enter.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_rd_n = wr_rd;
        addr_n  = address;
        rd_n    = cache_read;
        wr_n    = cache_write;
        busy_n  = busy;
        done_n  = done;
        clear_c = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear_c = 1'b1;
                    addr_n  = START;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    wr_rd_n = (mode == MODE_WRITE_READ);
                    if ((mode == MODE_WRITE) || (mode == MODE_WRITE_READ)) begin
                        state_n = ST_WRITE;
                        wr_n    = 1'b1;
                        rd_n    = 1'b0;
                    end else begin
                        state_n = ST_READ;
                        wr_n    = 1'b0;
                        rd_n    = 1'b1;
                    end
                end
            end
            ST_WRITE, ST_READ: begin
                if (cache_ready) begin
                    addr_n = address + STEP;
                    cnt_n  = cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        if ((state == ST_WRITE) && wr_rd) begin
                            state_n = ST_READ;
                            addr_n  = START;
                            cnt_n   = '0;
                            wr_n    = 1'b0;
                            rd_n    = 1'b1;
                        end else begin
                            state_n = ST_DONE;
                            wr_n    = 1'b0;
                            rd_n    = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wr_rd       <= 1'b0;
            address     <= START;
            write_data  <= DATA_W'(pattern(64'(START)));
            cache_read  <= 1'b0;
            cache_write <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= 32'h0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            wr_rd       <= wr_rd_n;
            address     <= addr_n;
            write_data  <= DATA_W'(pattern(64'(addr_n)));
            cache_read  <= rd_n;
            cache_write <= wr_n;
            busy        <= busy_n;
            done        <= done_n;
            if (clear_c) begin
                cycle_count <= 32'h0;
            end else if (busy && (cycle_count != 32'hFFFF_FFFF)) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

`ifdef CACHE_TRAFFIC_GEN_CHECK_EN
    // write_data always holds pattern(address), so it doubles as the expected read value.
    cache_traffic_checker #(
        .DATA_W (DATA_W)
    ) u_checker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear_c),
        .compare     (cache_read & cache_ready),
        .read_data   (read_data),
        .expected    (write_data),
        .error_count (error_count)
    );
`else
    logic unused_read_data;
    assign unused_read_data = ^read_data;
    assign error_count      = 16'h0;
`endif

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Randomized bench for cache_traffic_gen against an index-based behavioural model.
module tb_cache_traffic_gen;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
    localparam int unsigned SA = 1024;
    localparam int unsigned NA = 16;
    localparam int unsigned SD = 1;
`ifdef CACHE_TRAFFIC_GEN_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          cache_ready = 1'b0;
    logic [DW-1:0] read_data = '0;
    logic          cache_read, cache_write, busy, done;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic [15:0]   error_count;
    logic [31:0]   cycle_count;

    logic          start_w = 1'b0;
    logic          w_read, w_write, w_busy, w_done;
    logic [3:0]    w_address;
    logic [31:0]   w_write_data;
    logic [15:0]   w_error_count;
    logic [31:0]   w_cycle_count;

    always #5 clk = ~clk;

    cache_traffic_gen #(
        .ADDR_W(AW), .DATA_W(DW), .START_ADDR(SA), .NUM_ACCESS(NA), .STRIDE(SD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .cache_ready(cache_ready), .read_data(read_data),
        .cache_read(cache_read), .cache_write(cache_write), .address(address),
        .write_data(write_data), .busy(busy), .done(done),
        .error_count(error_count), .cycle_count(cycle_count)
    );

    cache_traffic_gen #(
        .ADDR_W(4), .DATA_W(32), .START_ADDR(14), .NUM_ACCESS(4), .STRIDE(1)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start_w), .mode(2'd0),
        .cache_ready(1'b1), .read_data(32'h0),
        .cache_read(w_read), .cache_write(w_write), .address(w_address),
        .write_data(w_write_data), .busy(w_busy), .done(w_done),
        .error_count(w_error_count), .cycle_count(w_cycle_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int unsigned a);
        return 32'(a) ^ 32'hA5A5_A5A5;
    endfunction

    // Model: run described by pass type and completed-access index.
    bit          m_busy = 0, m_done = 0, m_rd_phase = 0, m_wr_rd = 0;
    int unsigned m_idx = 0, m_err = 0, m_cyc = 0;
    logic [31:0] mem [int];

    function automatic int unsigned m_addr();
        return (SA + m_idx * SD) % (1 << AW);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_rd_phase = 0; m_wr_rd = 0;
            m_idx = 0; m_err = 0; m_cyc = 0;
        end else begin
            if (cache_write && cache_ready) mem[int'(address)] = write_data;
            if (m_busy && m_cyc != 32'hFFFF_FFFF) m_cyc++;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_done = 0; m_idx = 0; m_err = 0; m_cyc = 0;
                    m_wr_rd    = (mode == 2'd2);
                    m_rd_phase = !(mode == 2'd1 || mode == 2'd2);
                end
            end else if (cache_ready) begin
                if (CHECK && m_rd_phase && read_data != pat(m_addr()) && m_err != 16'hFFFF) m_err++;
                m_idx++;
                if (m_idx == NA) begin
                    if (!m_rd_phase && m_wr_rd) begin
                        m_rd_phase = 1; m_idx = 0;
                    end else begin
                        m_busy = 0; m_done = 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("cache_read",  64'(cache_read),  64'(m_busy && m_rd_phase));
            check("cache_write", 64'(cache_write), 64'(m_busy && !m_rd_phase));
            check("address",     64'(address),     64'(m_addr()));
            check("write_data",  64'(write_data),  64'(pat(m_addr())));
            check("busy",        64'(busy),        64'(m_busy));
            check("done",        64'(done),        64'(m_done));
            check("error_count", 64'(error_count), 64'(m_err));
            check("cycle_count", 64'(cycle_count), 64'(m_cyc));
        end
    end

    // Stimulus: cache_ready and read_data are refreshed on every falling edge.
    int ready_mode = 0;
    int ready_cnt  = 0;
    int density    = 100;

    task automatic tick();
        @(negedge clk);
        ready_cnt++;
        case (ready_mode)
            0:       cache_ready = 1'b1;
            1:       cache_ready = (ready_cnt % 3 == 0);
            default: cache_ready = ($urandom_range(99) < density);
        endcase
        read_data = mem.exists(int'(address)) ? mem[int'(address)] : $urandom;
    endtask

    task automatic do_start(input logic [1:0] m);
        tick();
        start = 1'b1;
        mode = m;
        ready_cnt = 0;
        tick();
        start = 1'b0;
        mode = 2'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rand_start);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            if (rand_start) start = ($urandom_range(3) == 0);
            mode = 2'($urandom);
            n++;
        end
        start = 1'b0;
        check("wait_done", 64'(done), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_read"},  64'(cache_read),  64'd0);
        check({tag, "_write"}, 64'(cache_write), 64'd0);
        check({tag, "_addr"},  64'(address),     64'd1024);
        check({tag, "_wdata"}, 64'(write_data),  64'hA5A5_A1A5);
        check({tag, "_busy"},  64'(busy),        64'd0);
        check({tag, "_done"},  64'(done),        64'd0);
        check({tag, "_err"},   64'(error_count), 64'd0);
        check({tag, "_cyc"},   64'(cycle_count), 64'd0);
    endtask

    initial begin
        int n;
        int k;
        int exp_w[4];
        logic [3:0] seq[4];

        #1 rst_n = 1'b0;
        #2 check_reset_vals("reset");
        tick(); tick();
        rst_n = 1'b1;

        // Zero-wait read pass.
        ready_mode = 0;
        do_start(2'd0);
        check("t1_first_addr", 64'(address), 64'd1024);
        check("t1_first_read", 64'(cache_read), 64'd1);
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        check("t1_busy_cycles", 64'(n), 64'd16);
        check("t1_cycle_count", 64'(cycle_count), 64'd16);
        check("t1_done", 64'(done), 64'd1);
        check("t1_final_addr", 64'(address), 64'd1040);

        // Write pass, ready every third cycle.
        ready_mode = 1;
        do_start(2'd1);
        check("t2_first_wdata", 64'(write_data), 64'hA5A5_A1A5);
        check("t2_first_write", 64'(cache_write), 64'd1);
        wait_done(200, 1'b0);
        check("t2_cycle_count", 64'(cycle_count), 64'd48);
        check("t2_mem_first", 64'(mem[1024]), 64'hA5A5_A1A5);

        // Write-then-verify against memory, then one corrupted word.
        ready_mode = 2; density = 60;
        do_start(2'd2);
        wait_done(500, 1'b0);
        check("t3_err_clean", 64'(error_count), 64'd0);
        mem[1030] = mem[1030] ^ 32'h1;
        ready_mode = 0;
        do_start(2'd0);
        wait_done(100, 1'b0);
        check("t3_err_corrupt", 64'(error_count), CHECK ? 64'd1 : 64'd0);
        mem[1030] = mem[1030] ^ 32'h1;

        // Randomized runs with start pulses while busy and ready noise while done.
        for (int r = 0; r < 10; r++) begin
            ready_mode = 2;
            density = $urandom_range(20, 100);
            k = $urandom_range(4);
            for (int i = 0; i < k; i++) tick();
            do_start(2'($urandom));
            wait_done(2000, 1'b1);
        end

        // Asynchronous reset mid-read.
        ready_mode = 0;
        do_start(2'd0);
        n = 0;
        while (address != 15'd1030 && n < 50) begin tick(); n++; end
        check("t5_reach_1030", 64'(address), 64'd1030);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        tick(); tick();
        rst_n = 1'b1;
        do_start(2'd0);
        check("t5_restart_addr", 64'(address), 64'd1024);
        check("t5_restart_read", 64'(cache_read), 64'd1);
        wait_done(100, 1'b0);

        // Address wrap in a 4-bit address space.
        exp_w[0] = 14; exp_w[1] = 15; exp_w[2] = 0; exp_w[3] = 1;
        tick();
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (w_busy && k < 4) begin seq[k] = w_address; k++; end
            tick();
        end
        check("wrap_count", 64'(k), 64'd4);
        for (int i = 0; i < 4; i++) check("wrap_addr", 64'(seq[i]), 64'(exp_w[i]));
        check("wrap_done", 64'(w_done), 64'd1);
        check("wrap_cycles", 64'(w_cycle_count), 64'd4);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
